// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin owner of the shared block-transfer path.
// Latches one I/D request, drives the downstream starts, returns the block.
module cache_port_arbiter #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int BLOCK_WIDTH    = 512,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      ic_start_read_i,
  input  logic [AXI_ADDR_WIDTH-1:0] ic_addr_i,
  output logic                      ic_done_o,
  output logic [BLOCK_WIDTH-1:0]    ic_data_block_o,
  input  logic                      dc_start_read_i,
  input  logic                      dc_start_write_i,
  input  logic [AXI_ADDR_WIDTH-1:0] dc_addr_i,
  input  logic [BLOCK_WIDTH-1:0]    dc_data_block_i,
  output logic                      dc_done_o,
  output logic [BLOCK_WIDTH-1:0]    dc_data_block_o,
  output logic                      axi_read_start_o,
  output logic                      axi_write_start_o,
  output logic [AXI_ADDR_WIDTH-1:0] axi_addr_o,
  output logic [BLOCK_WIDTH-1:0]    data_block_o,
  input  logic                      axi_done_i,
  input  logic [BLOCK_WIDTH-1:0]    data_block_i,
  output logic                      busy_o,
  output logic                      grant_o,
  output logic                      timeout_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CMAX =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] CNT_MAX = CW'(CMAX);

  logic [1:0]                state_q, state_d;
  logic                      last_q, last_d;
  logic                      grant_q, grant_d;
  logic                      wr_op_q, wr_op_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BLOCK_WIDTH-1:0]    wblk_q, wblk_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      to_q, to_d;
  logic                      rd_st_q, rd_st_d;
  logic                      wr_st_q, wr_st_d;
  logic                      icd_q, icd_d;
  logic                      dcd_q, dcd_d;
  logic [BLOCK_WIDTH-1:0]    icblk_q, icblk_d;
  logic [BLOCK_WIDTH-1:0]    dcblk_q, dcblk_d;
  logic                      busy_q, busy_d;
  logic                      req_i, req_d, gnt;

  assign req_i = ic_start_read_i;
  assign req_d = dc_start_read_i | dc_start_write_i;

  // Next-state: arbitrate in IDLE, drive starts in BUSY, wait out done in RELEASE
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    wr_op_d = wr_op_q;
    addr_d  = addr_q;
    wblk_d  = wblk_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    rd_st_d = 1'b0;
    wr_st_d = 1'b0;
    icd_d   = 1'b0;
    dcd_d   = 1'b0;
    icblk_d = icblk_q;
    dcblk_d = dcblk_q;
    gnt     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_i || req_d) begin
          gnt     = req_d && (!req_i || !last_q);
          grant_d = gnt;
          last_d  = gnt;
          wr_op_d = gnt & dc_start_write_i;
          addr_d  = gnt ? dc_addr_i : ic_addr_i;
          if (gnt) wblk_d = dc_data_block_i;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_MAX)
          to_d = 1'b1;
        if (axi_done_i) begin
          state_d = S_REL;
          if (grant_q) begin
            dcd_d = 1'b1;
            if (!wr_op_q) dcblk_d = data_block_i;
          end else begin
            icd_d   = 1'b1;
            icblk_d = data_block_i;
          end
        end else begin
          rd_st_d = !wr_op_q;
          wr_st_d = wr_op_q;
        end
      end
      S_REL: begin
        if (!axi_done_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset aborts any transfer in flight
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      wr_op_q <= 1'b0;
      addr_q  <= '0;
      wblk_q  <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      rd_st_q <= 1'b0;
      wr_st_q <= 1'b0;
      icd_q   <= 1'b0;
      dcd_q   <= 1'b0;
      icblk_q <= '0;
      dcblk_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      wr_op_q <= wr_op_d;
      addr_q  <= addr_d;
      wblk_q  <= wblk_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      rd_st_q <= rd_st_d;
      wr_st_q <= wr_st_d;
      icd_q   <= icd_d;
      dcd_q   <= dcd_d;
      icblk_q <= icblk_d;
      dcblk_q <= dcblk_d;
      busy_q  <= busy_d;
    end
  end

  assign ic_done_o         = icd_q;
  assign ic_data_block_o   = icblk_q;
  assign dc_done_o         = dcd_q;
  assign dc_data_block_o   = dcblk_q;
  assign axi_read_start_o  = rd_st_q;
  assign axi_write_start_o = wr_st_q;
  assign axi_addr_o        = addr_q;
  assign data_block_o      = wblk_q;
  assign busy_o            = busy_q;
  assign grant_o           = grant_q;
  assign timeout_o         = to_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: directed scenarios, cycle-level reference model
// and a per-cycle compare of every output.
module tb_cache_port_arbiter;

  localparam int AW = 64;
  localparam int BW = 512;
  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          arst_i = 1'b0;
  logic          ic_start_read_i = 1'b0;
  logic [AW-1:0] ic_addr_i = '0;
  logic          ic_done_o;
  logic [BW-1:0] ic_data_block_o;
  logic          dc_start_read_i = 1'b0;
  logic          dc_start_write_i = 1'b0;
  logic [AW-1:0] dc_addr_i = '0;
  logic [BW-1:0] dc_data_block_i = '0;
  logic          dc_done_o;
  logic [BW-1:0] dc_data_block_o;
  logic          axi_read_start_o;
  logic          axi_write_start_o;
  logic [AW-1:0] axi_addr_o;
  logic [BW-1:0] data_block_o;
  logic          axi_done_i = 1'b0;
  logic [BW-1:0] data_block_i = '1;
  logic          busy_o;
  logic          grant_o;
  logic          timeout_o;

  cache_port_arbiter #(
    .AXI_ADDR_WIDTH(AW),
    .BLOCK_WIDTH(BW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i),
    .arst_i(arst_i),
    .ic_start_read_i(ic_start_read_i),
    .ic_addr_i(ic_addr_i),
    .ic_done_o(ic_done_o),
    .ic_data_block_o(ic_data_block_o),
    .dc_start_read_i(dc_start_read_i),
    .dc_start_write_i(dc_start_write_i),
    .dc_addr_i(dc_addr_i),
    .dc_data_block_i(dc_data_block_i),
    .dc_done_o(dc_done_o),
    .dc_data_block_o(dc_data_block_o),
    .axi_read_start_o(axi_read_start_o),
    .axi_write_start_o(axi_write_start_o),
    .axi_addr_o(axi_addr_o),
    .data_block_o(data_block_o),
    .axi_done_i(axi_done_i),
    .data_block_i(data_block_i),
    .busy_o(busy_o),
    .grant_o(grant_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  logic          e_rd = 0, e_wr = 0, e_icd = 0, e_dcd = 0;
  logic          e_busy = 0, e_grant = 0, e_to = 0;
  logic [AW-1:0] e_addr = '0;
  logic [BW-1:0] e_wdata = '0, e_icdata = '0, e_dcdata = '0;
  int            m_phase = 0;
  int            m_n = 0;
  logic          m_last = 1'b1, m_side = 1'b0, m_w = 1'b0;

  // 0 = I-cache, 1 = D-cache; a lone requester wins, a tie goes
  // to whoever was not served last.
  function automatic logic pick(input logic ri, input logic rd,
                                input logic last);
    return rd && (!ri || !last);
  endfunction

  always @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      e_rd <= 0; e_wr <= 0; e_icd <= 0; e_dcd <= 0;
      e_busy <= 0; e_grant <= 0; e_to <= 0;
      e_addr <= '0; e_wdata <= '0;
      e_icdata <= '0; e_dcdata <= '0;
      m_phase <= 0; m_n <= 0; m_last <= 1'b1;
      m_side <= 1'b0; m_w <= 1'b0;
    end else begin
      e_icd <= 0;
      e_dcd <= 0;
      if (m_phase == 0) begin
        if (ic_start_read_i || dc_start_read_i || dc_start_write_i) begin
          m_side  <= pick(ic_start_read_i,
                          dc_start_read_i | dc_start_write_i, m_last);
          m_last  <= pick(ic_start_read_i,
                          dc_start_read_i | dc_start_write_i, m_last);
          e_grant <= pick(ic_start_read_i,
                          dc_start_read_i | dc_start_write_i, m_last);
          if (pick(ic_start_read_i,
                   dc_start_read_i | dc_start_write_i, m_last)) begin
            m_w     <= dc_start_write_i;
            e_addr  <= dc_addr_i;
            e_wdata <= dc_data_block_i;
          end else begin
            m_w    <= 1'b0;
            e_addr <= ic_addr_i;
          end
          m_n     <= 0;
          m_phase <= 1;
          e_busy  <= 1;
        end
      end else if (m_phase == 1) begin
        m_n <= m_n + 1;
        if (m_n + 1 >= TO) e_to <= 1;
        if (axi_done_i) begin
          e_rd <= 0;
          e_wr <= 0;
          m_phase <= 2;
          if (m_side) begin
            e_dcd <= 1;
            if (!m_w) e_dcdata <= data_block_i;
          end else begin
            e_icd <= 1;
            e_icdata <= data_block_i;
          end
        end else begin
          e_rd <= !m_w;
          e_wr <= m_w;
        end
      end else begin
        if (!axi_done_i) begin
          m_phase <= 0;
          e_busy <= 0;
        end
      end
    end
  end

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  int lat = 4, hold = 1, scnt = 0, hcnt = 0;
  logic [BW-1:0] resp = '0;
  logic hold_req = 0;
  int hold_until = 0;
  int rd_cyc, wr_cyc, busy_cyc, ic_p, dc_p, n_ord, first_op;
  logic [15:0] ord_v;
  logic [AW-1:0] first_addr;
  logic [BW-1:0] wr_seen;

  task automatic chk(input string name, input logic [BW-1:0] act,
                     input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    rd_cyc = 0; wr_cyc = 0; busy_cyc = 0; ic_p = 0; dc_p = 0;
    n_ord = 0; ord_v = '0; first_op = -1;
    first_addr = '0; wr_seen = '0;
  endtask

  // One cycle: compare, monitor, then drive caches and downstream
  task automatic step();
    @(negedge clk_i);
    chk("rd_start", BW'(axi_read_start_o), BW'(e_rd));
    chk("wr_start", BW'(axi_write_start_o), BW'(e_wr));
    chk("addr", BW'(axi_addr_o), BW'(e_addr));
    chk("wdata", data_block_o, e_wdata);
    chk("ic_done", BW'(ic_done_o), BW'(e_icd));
    chk("dc_done", BW'(dc_done_o), BW'(e_dcd));
    chk("ic_data", ic_data_block_o, e_icdata);
    chk("dc_data", dc_data_block_o, e_dcdata);
    chk("busy", BW'(busy_o), BW'(e_busy));
    chk("grant", BW'(grant_o), BW'(e_grant));
    chk("timeout", BW'(timeout_o), BW'(e_to));
    if (axi_read_start_o) rd_cyc++;
    if (axi_write_start_o) begin
      wr_cyc++;
      if (wr_cyc == 1) wr_seen = data_block_o;
    end
    if (first_op < 0 && (axi_read_start_o || axi_write_start_o)) begin
      first_op = axi_write_start_o ? 1 : 0;
      first_addr = axi_addr_o;
    end
    if (busy_o) busy_cyc++;
    if (ic_done_o) begin
      ic_p++; n_ord++; ord_v = {ord_v[14:0], 1'b0};
    end
    if (dc_done_o) begin
      dc_p++; n_ord++; ord_v = {ord_v[14:0], 1'b1};
    end
    if (hold_req) begin
      if (n_ord >= hold_until) begin
        hold_req = 0;
        ic_start_read_i = 0;
        dc_start_read_i = 0;
        dc_start_write_i = 0;
      end
    end else begin
      if (ic_done_o) ic_start_read_i = 0;
      if (dc_done_o) begin
        if (dc_start_write_i) dc_start_write_i = 0;
        else dc_start_read_i = 0;
      end
    end
    if (!arst_i) begin
      axi_done_i = 0; scnt = 0; hcnt = 0;
    end else if (axi_done_i) begin
      hcnt++;
      if (hcnt >= hold) begin
        axi_done_i = 0; hcnt = 0; data_block_i = ~resp;
      end
    end else if ((axi_read_start_o || axi_write_start_o) && lat != 0) begin
      scnt++;
      if (scnt >= lat) begin
        axi_done_i = 1; scnt = 0; data_block_i = resp;
      end
    end
  endtask

  task automatic run_quiet(input string name, input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((ic_start_read_i || dc_start_read_i || dc_start_write_i ||
                busy_o || axi_done_i) && n < budget);
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s timed out act=%0d cycles req=<%0d", name, n, budget);
    end
  endtask

  task automatic do_reset();
    #1 arst_i = 0;
    ic_start_read_i = 0;
    dc_start_read_i = 0;
    dc_start_write_i = 0;
    hold_req = 0;
    step();
    step();
    arst_i = 1;
  endtask

  initial begin
    clear_mon();
    // reset state
    step();
    step();
    chk("rst_busy", BW'(busy_o), BW'(0));
    chk("rst_grant", BW'(grant_o), BW'(0));
    chk("rst_timeout", BW'(timeout_o), BW'(0));
    chk("rst_rd", BW'(axi_read_start_o), BW'(0));
    arst_i = 1;
    step();

    // single I-cache read, 16-cycle downstream
    clear_mon();
    lat = 16; hold = 1; resp = {64{8'hAB}};
    ic_addr_i = 64'h1000; ic_start_read_i = 1;
    run_quiet("s1", 100);
    chk("s1_rd_cycles", BW'(rd_cyc), BW'(16));
    chk("s1_addr", BW'(first_addr), BW'(64'h1000));
    chk("s1_ic_pulses", BW'(ic_p), BW'(1));
    chk("s1_dc_pulses", BW'(dc_p), BW'(0));
    chk("s1_ic_data", ic_data_block_o, {64{8'hAB}});

    // simultaneous reads after reset: I then D
    do_reset();
    clear_mon();
    lat = 3; hold = 1; resp = {16{32'h1234_5678}};
    ic_addr_i = 64'h100; dc_addr_i = 64'h200;
    ic_start_read_i = 1; dc_start_read_i = 1;
    run_quiet("s2", 100);
    chk("s2_count", BW'(n_ord), BW'(2));
    chk("s2_order", BW'(ord_v), BW'(16'b01));

    // both held: strict alternation
    clear_mon();
    hold_req = 1; hold_until = 4;
    ic_start_read_i = 1; dc_start_read_i = 1;
    run_quiet("s2b", 200);
    chk("s2b_count", BW'(n_ord), BW'(4));
    chk("s2b_order", BW'(ord_v), BW'(16'b0101));

    // D write-back before refill
    do_reset();
    clear_mon();
    lat = 4; hold = 1; resp = {8{64'hC0FF_EE00_5555_AAAA}};
    dc_addr_i = 64'h2040;
    dc_data_block_i = {16{32'hDEAD_BEEF}};
    dc_start_write_i = 1; dc_start_read_i = 1;
    run_quiet("s3", 100);
    chk("s3_first_write", BW'(first_op), BW'(1));
    chk("s3_addr", BW'(first_addr), BW'(64'h2040));
    chk("s3_wr_cycles", BW'(wr_cyc), BW'(4));
    chk("s3_rd_cycles", BW'(rd_cyc), BW'(4));
    chk("s3_wdata", wr_seen, {16{32'hDEAD_BEEF}});
    chk("s3_dc_pulses", BW'(dc_p), BW'(2));
    chk("s3_dc_data", dc_data_block_o, {8{64'hC0FF_EE00_5555_AAAA}});

    // done held three cycles
    do_reset();
    clear_mon();
    lat = 2; hold = 3; resp = {64{8'h5A}};
    dc_addr_i = 64'h4000; dc_start_read_i = 1;
    run_quiet("s4", 100);
    chk("s4_dc_pulses", BW'(dc_p), BW'(1));
    chk("s4_busy_cycles", BW'(busy_cyc), BW'(6));

    // watchdog: no downstream completion
    do_reset();
    clear_mon();
    lat = 0; hold = 1; resp = {64{8'h33}};
    ic_addr_i = 64'h3000; ic_start_read_i = 1;
    begin
      int n;
      n = 0;
      do begin
        step();
        n++;
      end while (!busy_o && n < 5);
      for (int b = 1; b < 8; b++) step();
      chk("s5_to_before", BW'(timeout_o), BW'(0));
      step();
      chk("s5_to_after", BW'(timeout_o), BW'(1));
      chk("s5_start_held", BW'(axi_read_start_o), BW'(1));
    end
    lat = 1;
    run_quiet("s5", 100);
    chk("s5_ic_pulses", BW'(ic_p), BW'(1));
    chk("s5_to_sticky", BW'(timeout_o), BW'(1));

    // reset mid-BUSY, then first tie goes to I
    do_reset();
    clear_mon();
    lat = 20; hold = 1; resp = {64{8'h77}};
    ic_addr_i = 64'h5000; ic_start_read_i = 1;
    for (int k = 0; k < 12; k++) step();
    #1 arst_i = 0;
    #1;
    chk("s6_rd", BW'(axi_read_start_o), BW'(0));
    chk("s6_wr", BW'(axi_write_start_o), BW'(0));
    chk("s6_busy", BW'(busy_o), BW'(0));
    chk("s6_timeout", BW'(timeout_o), BW'(0));
    chk("s6_ic_done", BW'(ic_done_o), BW'(0));
    chk("s6_dc_done", BW'(dc_done_o), BW'(0));
    ic_start_read_i = 0;
    step();
    step();
    arst_i = 1;
    clear_mon();
    lat = 3;
    ic_start_read_i = 1; dc_start_read_i = 1;
    run_quiet("s6", 100);
    chk("s6_order", BW'(ord_v), BW'(16'b01));
    chk("s6_count", BW'(n_ord), BW'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
